// File: rtl/des_key_schedule_pkg.sv
// Shared DES key-schedule definitions: round count, shift table,
// PC-1 / PC-2 selection tables, FSM state type and rotate helpers.
// Bit numbering follows DES: index 1 is the leftmost (most significant) bit.
package des_key_schedule_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_e;

  // PC-1: 56 key bits selected from the 64-bit key (parity bits dropped)
  localparam int PC1_TAB [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 48 subkey bits selected from the 56-bit {C,D}
  localparam int PC2_TAB [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Shift table S[j]: one position in rounds 1, 2, 9 and 16, two elsewhere
  function automatic logic [1:0] shift_amt(input logic [4:0] j);
    case (j)
      5'd1, 5'd2, 5'd9, 5'd16: return 2'd1;
      default:                 return 2'd2;
    endcase
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    r = '0;
    for (int i = 1; i <= 56; i++) begin
      r[i] = k[PC1_TAB[i]];
    end
    return r;
  endfunction

  // Rotate a 28-bit half left (toward bit 1) by one or two positions
  function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[2:28], x[1]};
      default: return {x[3:28], x[1:2]};
    endcase
  endfunction

  // Rotate a 28-bit half right by one or two positions (undoes rotl28)
  function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[28], x[1:27]};
      default: return {x[27:28], x[1:26]};
    endcase
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle of the DES key schedule.
// master = key supplier and subkey consumer, slave = the key schedule.
interface des_key_schedule_if;
  logic        key_valid;
  logic        key_ready;
  logic [1:64] key;
  logic        decrypt;
  logic        abort;
  logic        sk_valid;
  logic        sk_ready;
  logic [0:47] subkey;
  logic [3:0]  sk_step;
  logic        sk_last;

  modport master (
    output key_valid, key, decrypt, abort, sk_ready,
    input  key_ready, sk_valid, subkey, sk_step, sk_last
  );

  modport slave (
    input  key_valid, key, decrypt, abort, sk_ready,
    output key_ready, sk_valid, subkey, sk_step, sk_last
  );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// DES permuted choice 2: compresses the 56-bit {C,D} into a 48-bit
// round subkey ordered like the E-expansion output.
module des_pc2
  import des_key_schedule_pkg::*;
(
  input  logic [1:56] cd,
  output logic [0:47] subkey
);

  // Bits of {C,D} that PC-2 never selects
  logic unused_s;
  assign unused_s = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};

  // Table-driven bit selection
  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[i] = cd[PC2_TAB[i + 1]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator. Holds only C/D and a step counter and
// walks them forward (encrypt, K1..K16) or backward (decrypt, K16..K1),
// presenting one registered PC-2 subkey per consumer handshake.
module des_key_schedule
  import des_key_schedule_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  des_key_schedule_if.slave bus
);

  if (ROUNDS != DES_ROUNDS) begin : g_bad_rounds
    $error("des_key_schedule: ROUNDS must be 16");
  end

  ks_state_e   state_r;
  logic [1:28] c_r;
  logic [1:28] d_r;
  logic [3:0]  step_r;
  logic        dir_r;
  logic        sk_valid_r;
  logic [0:47] subkey_r;
  logic        sk_last_r;
  logic        key_ready_r;

  logic [1:56] load_cd_s;
  logic [1:56] key_cd_s;
  logic [1:56] run_cd_s;
  logic [1:56] cd_nxt_s;
  logic [0:47] pc2_s;
  logic [4:0]  enc_j_s;
  logic [4:0]  dec_j_s;

  // Round numbers driving the next rotation: encrypt moves to round s+2,
  // decrypt undoes the shift of the current round 16-s
  always_comb begin
    enc_j_s = {1'b0, step_r} + 5'd2;
    dec_j_s = 5'd16 - {1'b0, step_r};
  end

  // Next {C,D}: freshly loaded key in IDLE, one rotation step in RUN
  always_comb begin
    load_cd_s = pc1(bus.key);
    if (bus.decrypt) begin
      key_cd_s = load_cd_s;  // C0D0 already yields K16
    end else begin
      key_cd_s = {rotl28(load_cd_s[1:28], 2'd1), rotl28(load_cd_s[29:56], 2'd1)};
    end
    if (dir_r) begin
      run_cd_s = {rotr28(c_r, shift_amt(dec_j_s)), rotr28(d_r, shift_amt(dec_j_s))};
    end else begin
      run_cd_s = {rotl28(c_r, shift_amt(enc_j_s)), rotl28(d_r, shift_amt(enc_j_s))};
    end
    if (state_r == IDLE) begin
      cd_nxt_s = key_cd_s;
    end else begin
      cd_nxt_s = run_cd_s;
    end
  end

  // Subkey for the {C,D} about to be registered
  des_pc2 u_pc2 (
    .cd     (cd_nxt_s),
    .subkey (pc2_s)
  );

  // Schedule FSM; subkey is registered together with C/D so it stays
  // stable for as long as the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      c_r         <= '0;
      d_r         <= '0;
      step_r      <= 4'd0;
      dir_r       <= 1'b0;
      sk_valid_r  <= 1'b0;
      subkey_r    <= '0;
      sk_last_r   <= 1'b0;
      key_ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (!bus.abort && bus.key_valid) begin
            c_r         <= cd_nxt_s[1:28];
            d_r         <= cd_nxt_s[29:56];
            subkey_r    <= pc2_s;
            dir_r       <= bus.decrypt;
            step_r      <= 4'd0;
            sk_valid_r  <= 1'b1;
            sk_last_r   <= 1'b0;
            key_ready_r <= 1'b0;
            state_r     <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            // A same-cycle handshake is consumed but nothing follows it
            sk_valid_r  <= 1'b0;
            sk_last_r   <= 1'b0;
            key_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else if (bus.sk_ready) begin
            if (step_r == 4'd15) begin
              sk_valid_r  <= 1'b0;
              sk_last_r   <= 1'b0;
              key_ready_r <= 1'b1;
              state_r     <= IDLE;
            end else begin
              c_r       <= cd_nxt_s[1:28];
              d_r       <= cd_nxt_s[29:56];
              subkey_r  <= pc2_s;
              step_r    <= step_r + 4'd1;
              sk_last_r <= (step_r == 4'd14);
            end
          end
        end
        default: begin
          sk_valid_r  <= 1'b0;
          sk_last_r   <= 1'b0;
          key_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.key_ready = key_ready_r;
  assign bus.sk_valid  = sk_valid_r;
  assign bus.subkey    = subkey_r;
  assign bus.sk_step   = step_r;
  assign bus.sk_last   = sk_last_r;

endmodule
